// File: rtl/tg68k_div_seq.sv
// Sequential 32/16 restoring divider for TG68K DIVU.W / DIVS.W.
// One quotient bit per enabled clock; all state advances only when clkena is high.
module tg68k_div_seq #(
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clkena,
    input  logic        start,
    input  logic        abort,
    input  logic        signed_op,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic [31:0] result,
    output logic        flag_n,
    output logic        flag_z,
    output logic        flag_v,
    output logic        flag_c
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_ITER, S_FIX, S_DONE} state_t;

    state_t      state, nxt;
    logic        op_signed;
    logic [31:0] dvd_in;
    logic [15:0] dsr_in;
    logic [15:0] dsr_mag;
    logic [15:0] rem;
    logic [15:0] sr;
    logic [3:0]  cnt;
    logic        qneg, rneg, hi_ovf;

    logic [31:0] mag_dvd;
    logic [15:0] mag_dsr;
    logic        dsr_zero, setup_ovf;
    logic [16:0] rem_sh;
    logic        q_bit;
    logic [15:0] rem_nxt;
    logic [15:0] quo, rmd;
    logic        fix_ovf;

    // Two's-complement negate of the most negative value yields the correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic signed [31:0] v, input logic sgn);
        return (sgn && v < 0) ? -v : v;
    endfunction

    function automatic logic [15:0] mag16(input logic signed [15:0] v, input logic sgn);
        return (sgn && v < 0) ? -v : v;
    endfunction

    function automatic logic [15:0] neg16(input logic [15:0] v, input logic n);
        return n ? -v : v;
    endfunction

    assign mag_dvd   = mag32(dvd_in, op_signed);
    assign mag_dsr   = mag16(dsr_in, op_signed);
    assign dsr_zero  = (dsr_in == 16'h0000);
    // A quotient wider than 16 bits exists exactly when the upper half is not below the divisor.
    assign setup_ovf = (mag_dvd[31:16] >= mag_dsr);

    // Upper half seeds the partial remainder; only the low 16 quotient bits are iterated.
    assign rem_sh  = {rem, sr[15]};
    assign q_bit   = (rem_sh >= {1'b0, dsr_mag});
    assign rem_nxt = q_bit ? (rem_sh[15:0] - dsr_mag) : rem_sh[15:0];

    assign quo     = neg16(sr, qneg);
    assign rmd     = neg16(rem, rneg);
    assign fix_ovf = hi_ovf | (op_signed & (qneg ? (sr > 16'h8000) : (sr > 16'h7FFF)));

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else if (clkena)
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        if (abort) begin
            nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) nxt = S_SETUP;
                S_SETUP: nxt = (dsr_zero || (EARLY_EXIT && setup_ovf)) ? S_DONE : S_ITER;
                S_ITER:  if (cnt == 4'd0) nxt = S_FIX;
                S_FIX:   nxt = S_DONE;
                S_DONE:  nxt = S_IDLE;
                default: nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_signed <= 1'b0;
            dvd_in    <= '0;
            dsr_in    <= '0;
            dsr_mag   <= '0;
            rem       <= '0;
            sr        <= '0;
            cnt       <= '0;
            qneg      <= 1'b0;
            rneg      <= 1'b0;
            hi_ovf    <= 1'b0;
            div_zero  <= 1'b0;
            result    <= '0;
            {flag_n, flag_z, flag_v, flag_c} <= 4'b0000;
        end else if (clkena && !abort) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_signed <= signed_op;
                        dvd_in    <= dividend;
                        dsr_in    <= divisor;
                    end
                end
                S_SETUP: begin
                    qneg    <= op_signed & (dvd_in[31] ^ dsr_in[15]);
                    rneg    <= op_signed & dvd_in[31];
                    dsr_mag <= mag_dsr;
                    rem     <= mag_dvd[31:16];
                    sr      <= mag_dvd[15:0];
                    cnt     <= 4'd15;
                    hi_ovf  <= setup_ovf;
                    if (dsr_zero) begin
                        div_zero <= 1'b1;
                        result   <= dvd_in;
                        {flag_n, flag_z, flag_v, flag_c} <= 4'b0000;
                    end else if (EARLY_EXIT && setup_ovf) begin
                        div_zero <= 1'b0;
                        result   <= dvd_in;
                        {flag_n, flag_z, flag_v, flag_c} <= 4'b0010;
                    end
                end
                S_ITER: begin
                    rem <= rem_nxt;
                    sr  <= {sr[14:0], q_bit};
                    cnt <= cnt - 4'd1;
                end
                S_FIX: begin
                    div_zero <= 1'b0;
                    if (fix_ovf) begin
                        result <= dvd_in;
                        {flag_n, flag_z, flag_v, flag_c} <= 4'b0010;
                    end else begin
                        result <= {rmd, quo};
                        {flag_n, flag_z, flag_v, flag_c} <= {quo[15], (quo == 16'h0000), 2'b00};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tg68k_div_seq.sv
// Directed bench for tg68k_div_seq: latency, results, flags, aborts, reset and clock-enable stalls.
module tb_tg68k_div_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [15:0] divisor = '0;
    logic        stall = 1'b0;
    logic        tog = 1'b0;
    logic        clkena;

    logic        busy1, done1, dz1, n1, z1, v1, c1;
    logic [31:0] res1;
    logic        busy0, done0, dz0, n0, z0, v0, c0;
    logic [31:0] res0;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;
    initial forever begin
        @(negedge clk);
        tog = ~tog;
    end
    assign clkena = stall ? tog : 1'b1;

    tg68k_div_seq #(.EARLY_EXIT(1'b1)) u_ee1 (
        .clk(clk), .reset(reset), .clkena(clkena), .start(start), .abort(abort),
        .signed_op(signed_op), .dividend(dividend), .divisor(divisor),
        .busy(busy1), .done(done1), .div_zero(dz1), .result(res1),
        .flag_n(n1), .flag_z(z1), .flag_v(v1), .flag_c(c1));

    tg68k_div_seq #(.EARLY_EXIT(1'b0)) u_ee0 (
        .clk(clk), .reset(reset), .clkena(clkena), .start(start), .abort(abort),
        .signed_op(signed_op), .dividend(dividend), .divisor(divisor),
        .busy(busy0), .done(done0), .div_zero(dz0), .result(res0),
        .flag_n(n0), .flag_z(z0), .flag_v(v0), .flag_c(c0));

    // Returns the enabled-cycle index in which done is first seen (start edge = cycle 0 -> 1), or -1.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input logic s,
                          input bit watch_ee0, output int cyc);
        int n;
        bit seen;
        n = 0;
        while ((busy1 || busy0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        dividend = a; divisor = b; signed_op = s; start = 1'b1;
        @(posedge clk);
        while (!clkena) @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge clk);
            if (watch_ee0 ? done0 : done1) seen = 1'b1;
            else begin
                @(posedge clk);
                if (clkena) n++;
            end
        end
        cyc = seen ? n : -1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy1); end
        checks++; if (done1 !== 1'b0) begin fails++; $display("FAIL reset_done got %b want 0", done1); end
        checks++; if (dz1 !== 1'b0) begin fails++; $display("FAIL reset_div_zero got %b want 0", dz1); end
        checks++; if (res1 !== 32'h0) begin fails++; $display("FAIL reset_result got %h want 0", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b0000) begin fails++; $display("FAIL reset_flags got %b want 0000", {n1, z1, v1, c1}); end
    endtask

    task automatic test_divu();
        int cyc;
        run_op(32'h000186A0, 16'h0007, 1'b0, 1'b0, cyc);
        checks++; if (cyc !== 19) begin fails++; $display("FAIL divu_latency got %0d want 19", cyc); end
        checks++; if (res1 !== 32'h000537CD) begin fails++; $display("FAIL divu_result got %h want 000537cd", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b0000) begin fails++; $display("FAIL divu_flags got %b want 0000", {n1, z1, v1, c1}); end
        @(negedge clk);
        checks++; if (done1 !== 1'b0) begin fails++; $display("FAIL divu_done_pulse got %b want 0", done1); end
        checks++; if (res1 !== 32'h000537CD) begin fails++; $display("FAIL divu_result_hold got %h want 000537cd", res1); end
        run_op(32'h00000005, 16'h0007, 1'b0, 1'b0, cyc);
        checks++; if (res1 !== 32'h00050000) begin fails++; $display("FAIL divu_zero_quo_result got %h want 00050000", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b0100) begin fails++; $display("FAIL divu_zero_quo_flags got %b want 0100", {n1, z1, v1, c1}); end
    endtask

    task automatic test_divs();
        int cyc;
        run_op(32'hFFFE7960, 16'h0007, 1'b1, 1'b0, cyc);
        checks++; if (cyc !== 19) begin fails++; $display("FAIL divs_latency got %0d want 19", cyc); end
        checks++; if (res1 !== 32'hFFFBC833) begin fails++; $display("FAIL divs_result got %h want fffbc833", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b1000) begin fails++; $display("FAIL divs_flags got %b want 1000", {n1, z1, v1, c1}); end
        run_op(32'h00008000, 16'h0001, 1'b1, 1'b0, cyc);
        checks++; if (cyc !== 19) begin fails++; $display("FAIL divs_posovf_latency got %0d want 19", cyc); end
        checks++; if (res1 !== 32'h00008000) begin fails++; $display("FAIL divs_posovf_result got %h want 00008000", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b0010) begin fails++; $display("FAIL divs_posovf_flags got %b want 0010", {n1, z1, v1, c1}); end
        run_op(32'hFFFF8000, 16'h0001, 1'b1, 1'b0, cyc);
        checks++; if (res1 !== 32'h00008000) begin fails++; $display("FAIL divs_minq_result got %h want 00008000", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b1000) begin fails++; $display("FAIL divs_minq_flags got %b want 1000", {n1, z1, v1, c1}); end
    endtask

    task automatic test_overflow();
        int cyc;
        run_op(32'h00070000, 16'h0007, 1'b0, 1'b0, cyc);
        checks++; if (cyc !== 2) begin fails++; $display("FAIL ovf_ee1_latency got %0d want 2", cyc); end
        checks++; if (res1 !== 32'h00070000) begin fails++; $display("FAIL ovf_ee1_result got %h want 00070000", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b0010) begin fails++; $display("FAIL ovf_ee1_flags got %b want 0010", {n1, z1, v1, c1}); end
        run_op(32'h00070000, 16'h0007, 1'b0, 1'b1, cyc);
        checks++; if (cyc !== 19) begin fails++; $display("FAIL ovf_ee0_latency got %0d want 19", cyc); end
        checks++; if (res0 !== 32'h00070000) begin fails++; $display("FAIL ovf_ee0_result got %h want 00070000", res0); end
        checks++; if ({n0, z0, v0, c0} !== 4'b0010) begin fails++; $display("FAIL ovf_ee0_flags got %b want 0010", {n0, z0, v0, c0}); end
    endtask

    task automatic test_div_zero();
        int cyc;
        run_op(32'h12345678, 16'h0000, 1'b1, 1'b0, cyc);
        checks++; if (cyc !== 2) begin fails++; $display("FAIL dz_latency got %0d want 2", cyc); end
        checks++; if (dz1 !== 1'b1) begin fails++; $display("FAIL dz_flag got %b want 1", dz1); end
        checks++; if (res1 !== 32'h12345678) begin fails++; $display("FAIL dz_result got %h want 12345678", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b0000) begin fails++; $display("FAIL dz_flags got %b want 0000", {n1, z1, v1, c1}); end
        run_op(32'h00000064, 16'h000A, 1'b0, 1'b0, cyc);
        checks++; if (dz1 !== 1'b0) begin fails++; $display("FAIL dz_cleared got %b want 0", dz1); end
        checks++; if (res1 !== 32'h0000000A) begin fails++; $display("FAIL dz_next_result got %h want 0000000a", res1); end
    endtask

    task automatic test_start_ignored();
        int n;
        @(negedge clk);
        dividend = 32'h000186A0; divisor = 16'h0007; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #1 dividend = 32'h0; divisor = 16'h0001; signed_op = 1'b1; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        while (!done1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (done1 !== 1'b1) begin fails++; $display("FAIL busy_start_done got %b want 1", done1); end
        checks++; if (res1 !== 32'h000537CD) begin fails++; $display("FAIL busy_start_result got %h want 000537cd", res1); end
    endtask

    task automatic test_abort();
        int cyc;
        bit seen;
        @(negedge clk);
        dividend = 32'h000186A0; divisor = 16'h0007; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (7) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL abort_busy got %b want 0", busy1); end
        seen = 1'b0;
        repeat (30) begin @(negedge clk); seen |= done1; end
        checks++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_no_done got %b want 0", seen); end
        run_op(32'hFFFE7960, 16'h0007, 1'b1, 1'b0, cyc);
        checks++; if (cyc !== 19) begin fails++; $display("FAIL abort_restart_latency got %0d want 19", cyc); end
        checks++; if (res1 !== 32'hFFFBC833) begin fails++; $display("FAIL abort_restart_result got %h want fffbc833", res1); end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        dividend = 32'h000186A0; divisor = 16'h0007; signed_op = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        checks++; if (busy1 !== 1'b0) begin fails++; $display("FAIL areset_busy got %b want 0", busy1); end
        checks++; if (res1 !== 32'h0) begin fails++; $display("FAIL areset_result got %h want 0", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b0000) begin fails++; $display("FAIL areset_flags got %b want 0000", {n1, z1, v1, c1}); end
        @(negedge clk); reset = 1'b0;
    endtask

    task automatic test_stall();
        int cyc;
        stall = 1'b1;
        run_op(32'hFFFE7960, 16'h0007, 1'b1, 1'b0, cyc);
        checks++; if (cyc !== 19) begin fails++; $display("FAIL stall_latency got %0d want 19", cyc); end
        checks++; if (res1 !== 32'hFFFBC833) begin fails++; $display("FAIL stall_result got %h want fffbc833", res1); end
        checks++; if ({n1, z1, v1, c1} !== 4'b1000) begin fails++; $display("FAIL stall_flags got %b want 1000", {n1, z1, v1, c1}); end
        @(posedge clk); #1;
        if (!clkena) begin
            @(negedge clk);
            checks++; if (done1 !== 1'b1) begin fails++; $display("FAIL stall_done_hold got %b want 1", done1); end
        end else begin
            @(negedge clk);
            checks++; if (done1 !== 1'b0) begin fails++; $display("FAIL stall_done_exit got %b want 0", done1); end
        end
        stall = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        test_reset();
        test_divu();
        test_divs();
        test_overflow();
        test_div_zero();
        test_start_ignored();
        test_abort();
        test_async_reset();
        test_stall();
        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
